// File: rtl/mc_stream_mmio_credit_if.sv
// Bundles the MMIO request/response and the two stream directions of the
// MMIO-to-stream bridge. Signal names are seen from the bridge (slave) side.
//   MMIO request : v_i, data_i, mask_i, addr_i, we_i, src_x_cord_i, src_y_cord_i -> yumi_o
//   MMIO response: v_o, data_o, err_o
//   stream rx    : stream_v_i, stream_data_i -> stream_ready_o
//   stream tx    : stream_v_o, stream_data_o <- stream_yumi_i
//   status       : outstanding_o
interface mc_stream_mmio_credit_if #(
    parameter int unsigned x_cord_width_p      = 8,
    parameter int unsigned y_cord_width_p      = 8,
    parameter int unsigned addr_width_p        = 32,
    parameter int unsigned data_width_p        = 32,
    parameter int unsigned stream_data_width_p = 16,
    parameter int unsigned max_outstanding_p   = 16
);
    localparam int unsigned MASK_W = data_width_p / 8;
    localparam int unsigned OUT_W  = $clog2(max_outstanding_p + 1);

    logic                           v_i;
    logic [data_width_p-1:0]        data_i;
    logic [MASK_W-1:0]              mask_i;
    logic [addr_width_p-1:0]        addr_i;
    logic                           we_i;
    logic [x_cord_width_p-1:0]      src_x_cord_i;
    logic [y_cord_width_p-1:0]      src_y_cord_i;
    logic                           yumi_o;
    logic                           v_o;
    logic [data_width_p-1:0]        data_o;
    logic                           err_o;
    logic                           stream_v_i;
    logic [stream_data_width_p-1:0] stream_data_i;
    logic                           stream_ready_o;
    logic                           stream_v_o;
    logic [stream_data_width_p-1:0] stream_data_o;
    logic                           stream_yumi_i;
    logic [OUT_W-1:0]               outstanding_o;

    modport slave (
        input  v_i, data_i, mask_i, addr_i, we_i, src_x_cord_i, src_y_cord_i,
        output yumi_o, v_o, data_o, err_o,
        input  stream_v_i, stream_data_i,
        output stream_ready_o, stream_v_o, stream_data_o,
        input  stream_yumi_i,
        output outstanding_o
    );

    modport master (
        output v_i, data_i, mask_i, addr_i, we_i, src_x_cord_i, src_y_cord_i,
        input  yumi_o, v_o, data_o, err_o,
        output stream_v_i, stream_data_i,
        input  stream_ready_o, stream_v_o, stream_data_o,
        output stream_yumi_i,
        input  outstanding_o
    );
endinterface

// File: rtl/mc_stream_mmio_credit.sv
// MMIO-to-stream bridge: serialises accepted MMIO requests {data,addr,mask,we,y,x}
// (x at LSBs) onto a narrow stream, LSB beat first, and rebuilds response packets
// into MMIO responses. Requests are tracked in order; optional write acks and a
// response timeout (error response, late reply discarded) are supported.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset
//   bus      - slave view of mc_stream_mmio_credit_if (MMIO req/resp, stream tx/rx, outstanding count)
module mc_stream_mmio_credit #(
    parameter int unsigned x_cord_width_p      = 8,
    parameter int unsigned y_cord_width_p      = 8,
    parameter int unsigned addr_width_p        = 32,
    parameter int unsigned data_width_p        = 32,
    parameter int unsigned stream_data_width_p = 16,
    parameter int unsigned max_outstanding_p   = 16,
    parameter int unsigned write_ack_p         = 0,
    parameter int unsigned timeout_p           = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    mc_stream_mmio_credit_if.slave bus
);
    localparam int unsigned SW        = stream_data_width_p;
    localparam int unsigned MASK_W    = data_width_p / 8;
    localparam int unsigned PKT_W     = data_width_p + addr_width_p + MASK_W + 1
                                        + y_cord_width_p + x_cord_width_p;
    localparam int unsigned REQ_BEATS = (PKT_W + SW - 1) / SW;
    localparam int unsigned PAD_W     = REQ_BEATS * SW;
    localparam int unsigned RSP_BEATS = data_width_p / SW;
    localparam int unsigned OUT_W     = $clog2(max_outstanding_p + 1);
    localparam int unsigned PTR_W     = $clog2(max_outstanding_p);
    localparam int unsigned BEAT_W    = (REQ_BEATS > 1) ? $clog2(REQ_BEATS) : 1;
    localparam int unsigned RX_W      = (RSP_BEATS > 1) ? $clog2(RSP_BEATS) : 1;
    localparam int unsigned WAIT_W    = $clog2(timeout_p + 2);

    typedef enum logic {SER_IDLE, SER_SEND} ser_state_e;

    ser_state_e                 ser_state_q, ser_state_d;
    logic [PAD_W-1:0]           ser_shift_q, ser_shift_d;
    logic [BEAT_W-1:0]          ser_beat_q, ser_beat_d;
    logic [max_outstanding_p-1:0] trk_we_q, trk_we_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OUT_W-1:0]           count_q, count_d;
    logic [data_width_p-1:0]    rx_data_q, rx_data_d;
    logic [RX_W-1:0]            rx_beat_q, rx_beat_d;
    logic                       rx_full_q, rx_full_d;
    logic [WAIT_W-1:0]          wait_q, wait_d;
    logic [OUT_W-1:0]           drop_q, drop_d;

    logic             ser_idle, ser_last, accept;
    logic             head_valid, head_we;
    logic             local_done, resp_done, drop_now, timeout_now, pop;
    logic [PAD_W-1:0] req_pkt;

    assign req_pkt = PAD_W'({bus.data_i, bus.addr_i, bus.mask_i, bus.we_i,
                             bus.src_y_cord_i, bus.src_x_cord_i});

    // Serialiser state register
    always_ff @(posedge clk_i) begin
        if (reset_i) ser_state_q <= SER_IDLE;
        else         ser_state_q <= ser_state_d;
    end

    // Serialiser next state: leave SEND once the last beat is consumed
    always_comb begin
        ser_state_d = ser_state_q;
        case (ser_state_q)
            SER_IDLE: if (accept) ser_state_d = SER_SEND;
            SER_SEND: if (ser_last) ser_state_d = SER_IDLE;
            default:  ser_state_d = SER_IDLE;
        endcase
    end

    // Serialiser outputs
    always_comb begin
        ser_idle          = (ser_state_q == SER_IDLE);
        bus.stream_v_o    = (ser_state_q == SER_SEND);
        bus.stream_data_o = ser_shift_q[SW-1:0];
        ser_last          = (ser_state_q == SER_SEND) && bus.stream_yumi_i
                            && (ser_beat_q == BEAT_W'(REQ_BEATS - 1));
    end

    // Serialiser datapath: load on accept, shift one beat per consumption
    always_comb begin
        ser_shift_d = ser_shift_q;
        ser_beat_d  = ser_beat_q;
        if (accept) begin
            ser_shift_d = req_pkt;
            ser_beat_d  = '0;
        end else if (bus.stream_v_o && bus.stream_yumi_i) begin
            ser_shift_d = ser_shift_q >> SW;
            ser_beat_d  = ser_beat_q + BEAT_W'(1);
        end
    end

    // Head completion: local write, matched response, or timeout (one per cycle)
    always_comb begin
        accept      = bus.v_i && ser_idle && !reset_i
                      && (count_q != OUT_W'(max_outstanding_p))
                      && (drop_q != OUT_W'(max_outstanding_p));
        head_valid  = (count_q != '0);
        head_we     = trk_we_q[rd_ptr_q];
        drop_now    = (drop_q != '0) && rx_full_q;
        local_done  = head_valid && head_we && (write_ack_p == 0);
        resp_done   = head_valid && !local_done && rx_full_q && !drop_now;
        // Fires on the timeout_p-th cycle the head has waited without completing
        timeout_now = (timeout_p != 0) && head_valid && !local_done && !resp_done
                      && (wait_q == WAIT_W'(timeout_p - 1));
        pop         = local_done || resp_done || timeout_now;
    end

    // MMIO response and status outputs
    always_comb begin
        bus.yumi_o         = accept;
        bus.v_o            = 1'b0;
        bus.err_o          = 1'b0;
        bus.data_o         = '0;
        bus.stream_ready_o = !rx_full_q;
        bus.outstanding_o  = count_q;
        if (!reset_i) begin
            bus.v_o   = pop;
            bus.err_o = timeout_now;
            if (resp_done && !head_we) bus.data_o = rx_data_q;
            else if (timeout_now)      bus.data_o = '1;
        end
    end

    // Tracking queue, wait counter and late-reply drop counter
    always_comb begin
        trk_we_d = trk_we_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = drop_q;
        if (accept) begin
            trk_we_d[wr_ptr_q] = bus.we_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(max_outstanding_p - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(max_outstanding_p - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + OUT_W'(accept) - OUT_W'(pop);
        wait_d  = (pop || !head_valid || (timeout_p == 0)) ? '0 : wait_q + WAIT_W'(1);
        if (timeout_now && !drop_now) begin
            if (drop_q != OUT_W'(max_outstanding_p)) drop_d = drop_q + OUT_W'(1);
        end else if (drop_now && !timeout_now) begin
            drop_d = drop_q - OUT_W'(1);
        end
    end

    // Deserialiser: beats shift in from the top so the first lands at the LSBs
    always_comb begin
        rx_data_d = rx_data_q;
        rx_beat_d = rx_beat_q;
        rx_full_d = rx_full_q;
        if (resp_done || drop_now) begin
            rx_full_d = 1'b0;
        end else if (bus.stream_v_i && !rx_full_q) begin
            rx_data_d = (rx_data_q >> SW)
                        | (data_width_p'(bus.stream_data_i) << (data_width_p - SW));
            if (rx_beat_q == RX_W'(RSP_BEATS - 1)) begin
                rx_beat_d = '0;
                rx_full_d = 1'b1;
            end else begin
                rx_beat_d = rx_beat_q + RX_W'(1);
            end
        end
    end

    // Datapath and bookkeeping registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ser_shift_q <= '0;
            ser_beat_q  <= '0;
            trk_we_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rx_data_q   <= '0;
            rx_beat_q   <= '0;
            rx_full_q   <= 1'b0;
            wait_q      <= '0;
            drop_q      <= '0;
        end else begin
            ser_shift_q <= ser_shift_d;
            ser_beat_q  <= ser_beat_d;
            trk_we_q    <= trk_we_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            rx_beat_q   <= rx_beat_d;
            rx_full_q   <= rx_full_d;
            wait_q      <= wait_d;
            drop_q      <= drop_d;
        end
    end
endmodule

// File: tb/tb_mc_stream_mmio_credit.sv
// Bench for mc_stream_mmio_credit. Two instances share one stimulus style:
//   d0: write_ack_p=0, timeout_p=0     d1: write_ack_p=1, timeout_p=8
// A queue-based model predicts every cycle's outputs; directed scenarios add
// hand-computed literal expectations.
module tb_mc_stream_mmio_credit;
    localparam int XW = 8, YW = 8, AW = 32, DW = 32, SW = 16, MO = 16;
    localparam int OW        = $clog2(MO + 1);
    localparam int REQ_BEATS = 6;
    localparam int RSP_BEATS = 2;
    localparam int TO1       = 8;

    logic clk;
    logic rst [2];
    logic v [2], we [2], sv [2], syumi [2];
    logic [DW-1:0]   wdata [2];
    logic [DW/8-1:0] wmask [2];
    logic [AW-1:0]   addr [2];
    logic [XW-1:0]   sx [2];
    logic [YW-1:0]   sy [2];
    logic [SW-1:0]   sdata [2];
    logic yumi [2], vo [2], erro [2], sready [2], svo [2];
    logic [DW-1:0] datao [2];
    logic [SW-1:0] sdo [2];
    logic [OW-1:0] outst [2];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_stream_mmio_credit_if #(
            .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW),
            .data_width_p(DW), .stream_data_width_p(SW), .max_outstanding_p(MO)
        ) bus ();
        assign bus.v_i           = v[g];
        assign bus.data_i        = wdata[g];
        assign bus.mask_i        = wmask[g];
        assign bus.addr_i        = addr[g];
        assign bus.we_i          = we[g];
        assign bus.src_x_cord_i  = sx[g];
        assign bus.src_y_cord_i  = sy[g];
        assign bus.stream_v_i    = sv[g];
        assign bus.stream_data_i = sdata[g];
        assign bus.stream_yumi_i = syumi[g];
        assign yumi[g]   = bus.yumi_o;
        assign vo[g]     = bus.v_o;
        assign datao[g]  = bus.data_o;
        assign erro[g]   = bus.err_o;
        assign sready[g] = bus.stream_ready_o;
        assign svo[g]    = bus.stream_v_o;
        assign sdo[g]    = bus.stream_data_o;
        assign outst[g]  = bus.outstanding_o;
        mc_stream_mmio_credit #(
            .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW),
            .data_width_p(DW), .stream_data_width_p(SW), .max_outstanding_p(MO),
            .write_ack_p(g), .timeout_p(g * TO1)
        ) dut (
            .clk_i  (clk),
            .reset_i(rst[g]),
            .bus    (bus)
        );
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: pending requests (we bits), beats still to send, beats received,
    // cycles the head has waited, late replies still to discard.
    bit            m_q     [2][$];
    logic [SW-1:0] m_beats [2][$];
    logic [SW-1:0] m_rx    [2][$];
    int            m_wait  [2];
    int            m_drop  [2];

    task automatic model_step(input int d);
        string t;
        int sz;
        bit hv, hwe, rxf, idle, e_yumi, drop, e_v, e_err, pop, cons, tmo;
        logic [DW-1:0] e_data;
        logic [95:0] pkt;
        if (rst[d]) begin
            m_q[d].delete(); m_beats[d].delete(); m_rx[d].delete();
            m_wait[d] = 0; m_drop[d] = 0;
            return;
        end
        t      = $sformatf("d%0d", d);
        sz     = m_q[d].size();
        hv     = (sz > 0);
        hwe    = hv ? m_q[d][0] : 1'b0;
        rxf    = (m_rx[d].size() == RSP_BEATS);
        idle   = (m_beats[d].size() == 0);
        e_yumi = v[d] && idle && (sz < MO) && (m_drop[d] < MO);
        drop   = (m_drop[d] > 0) && rxf;
        e_v = 0; e_err = 0; e_data = '0; pop = 0; cons = drop; tmo = 0;
        // instance index doubles as write_ack_p; only d1 has a timeout
        if (hv && hwe && d == 0) begin
            e_v = 1; pop = 1;
        end else if (hv && rxf && !drop) begin
            e_v = 1; pop = 1; cons = 1;
            if (!hwe) e_data = {m_rx[d][1], m_rx[d][0]};
        end else if (hv && d == 1 && m_wait[d] + 1 == TO1) begin
            e_v = 1; e_err = 1; e_data = '1; pop = 1; tmo = 1;
        end

        chk({t, "_yumi"},         64'(yumi[d]),   64'(e_yumi));
        chk({t, "_outstanding"},  64'(outst[d]),  64'(sz));
        chk({t, "_stream_v"},     64'(svo[d]),    64'(!idle));
        chk({t, "_stream_ready"}, 64'(sready[d]), 64'(!rxf));
        chk({t, "_v"},            64'(vo[d]),     64'(e_v));
        if (e_v) begin
            chk({t, "_data"}, 64'(datao[d]), 64'(e_data));
            chk({t, "_err"},  64'(erro[d]),  64'(e_err));
        end
        if (!idle) chk({t, "_stream_data"}, 64'(sdo[d]), 64'(m_beats[d][0]));

        if (syumi[d] && !idle) void'(m_beats[d].pop_front());
        if (pop) void'(m_q[d].pop_front());
        if (e_yumi) begin
            m_q[d].push_back(we[d]);
            pkt = 96'({wdata[d], addr[d], wmask[d], we[d], sy[d], sx[d]});
            for (int k = 0; k < REQ_BEATS; k++) m_beats[d].push_back(pkt[k*SW +: SW]);
        end
        m_wait[d] = (pop || !hv) ? 0 : m_wait[d] + 1;
        if (tmo && !drop) begin
            if (m_drop[d] < MO) m_drop[d]++;
        end else if (drop && !tmo) begin
            m_drop[d]--;
        end
        if (cons) m_rx[d].delete();
        else if (sv[d] && !rxf) m_rx[d].push_back(sdata[d]);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input int d, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] dt, input logic [DW/8-1:0] m,
                        input logic [XW-1:0] x, input logic [YW-1:0] y);
        bit got = 1'b0;
        v[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dt; wmask[d] = m; sx[d] = x; sy[d] = y;
        for (int i = 0; i < 200 && !got; i++) begin
            #3;
            got = yumi[d];
            cyc();
        end
        v[d] = 1'b0;
        if (!got) chk($sformatf("d%0d_accept_bound", d), 64'd0, 64'd1);
    endtask

    task automatic beat(input int d, input logic [SW-1:0] b);
        bit got = 1'b0;
        sv[d] = 1'b1; sdata[d] = b;
        for (int i = 0; i < 50 && !got; i++) begin
            #3;
            got = sready[d];
            cyc();
        end
        sv[d] = 1'b0;
        if (!got) chk($sformatf("d%0d_beat_bound", d), 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_at;
        logic got_err;
        logic [DW-1:0] got_data;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; v[d] = 1'b0; we[d] = 1'b0; wdata[d] = '0; wmask[d] = '0;
            addr[d] = '0; sx[d] = '0; sy[d] = '0; sv[d] = 1'b0; sdata[d] = '0; syumi[d] = 1'b1;
        end
        repeat (2) cyc();
        rst[0] = 1'b0; rst[1] = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_outstanding", d), 64'(outst[d]), 64'd0);
            chk($sformatf("d%0d_rst_stream_v", d),    64'(svo[d]),   64'd0);
            chk($sformatf("d%0d_rst_v", d),           64'(vo[d]),    64'd0);
            chk($sformatf("d%0d_rst_ready", d),       64'(sready[d]), 64'd1);
        end
        cyc();

        // Read 0x10: six request beats, beat0 = {y,x}; response 0xBEEF,0xDEAD
        send(0, 1'b0, 32'h10, 32'h0, 4'h0, 8'h12, 8'h34);
        #3;
        chk("t1_stream_v", 64'(svo[0]), 64'd1);
        chk("t1_beat0",    64'(sdo[0]), 64'h3412);
        cyc();
        repeat (5) cyc();
        #3;
        chk("t1_stream_done", 64'(svo[0]), 64'd0);
        cyc();
        beat(0, 16'hBEEF);
        beat(0, 16'hDEAD);
        #3;
        chk("t1_v",    64'(vo[0]),    64'd1);
        chk("t1_data", 64'(datao[0]), 64'hDEADBEEF);
        chk("t1_err",  64'(erro[0]),  64'd0);
        cyc();

        // Unacked write with the stream stalled: completes locally at once
        syumi[0] = 1'b0;
        send(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 8'h78, 8'h56);
        #3;
        chk("t2_v",        64'(vo[0]),    64'd1);
        chk("t2_data",     64'(datao[0]), 64'd0);
        chk("t2_stream_v", 64'(svo[0]),   64'd1);
        chk("t2_beat0",    64'(sdo[0]),   64'h5678);
        cyc();
        #3;
        chk("t2_beat0_held", 64'(sdo[0]),   64'h5678);
        chk("t2_outst_zero", 64'(outst[0]), 64'd0);
        cyc();
        syumi[0] = 1'b1;
        repeat (7) cyc();

        // Fill all 16 tracking slots with reads, then free one with a response
        for (int i = 0; i < 16; i++) send(0, 1'b0, 32'(32'h100 + i * 4), 32'h0, 4'h0, 8'(i), 8'h01);
        repeat (6) cyc();
        v[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h200;
        #3;
        chk("t3_full_outst", 64'(outst[0]), 64'd16);
        chk("t3_full_yumi",  64'(yumi[0]),  64'd0);
        cyc();
        beat(0, 16'h0001);
        beat(0, 16'h0002);
        #3;
        chk("t3_v",    64'(vo[0]),    64'd1);
        chk("t3_data", 64'(datao[0]), 64'h00020001);
        cyc();
        #3;
        chk("t3_outst_15", 64'(outst[0]), 64'd15);
        chk("t3_resume",   64'(yumi[0]),  64'd1);
        cyc();
        v[0] = 1'b0;
        rst[0] = 1'b1;
        cyc();
        rst[0] = 1'b0;
        cyc();

        // Reset after three of six request beats
        send(0, 1'b0, 32'h40, 32'h0, 4'h0, 8'h01, 8'h02);
        repeat (3) cyc();
        #3;
        chk("t4_mid_packet", 64'(svo[0]), 64'd1);
        rst[0] = 1'b1;
        cyc();
        rst[0] = 1'b0;
        #3;
        chk("t4_stream_v",  64'(svo[0]),    64'd0);
        chk("t4_outst",     64'(outst[0]),  64'd0);
        chk("t4_ready",     64'(sready[0]), 64'd1);
        cyc();
        send(0, 1'b0, 32'h44, 32'h0, 4'h0, 8'h03, 8'h04);
        beat(0, 16'hAAAA);
        beat(0, 16'h5555);
        #3;
        chk("t4_v",    64'(vo[0]),    64'd1);
        chk("t4_data", 64'(datao[0]), 64'h5555AAAA);
        cyc();
        repeat (6) cyc();

        // Acked write: completes only on its response packet, data_o=0
        send(1, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 8'h03, 8'h04);
        beat(1, 16'h1234);
        beat(1, 16'h0000);
        #3;
        chk("t5_v",    64'(vo[1]),    64'd1);
        chk("t5_data", 64'(datao[1]), 64'd0);
        chk("t5_err",  64'(erro[1]),  64'd0);
        cyc();
        repeat (6) cyc();

        // Timeout: error on the 8th wait cycle, late reply discarded
        send(1, 1'b0, 32'h90, 32'h0, 4'h0, 8'h05, 8'h06);
        got_at = 0; got_err = 1'b0; got_data = '0;
        for (int i = 1; i <= 20; i++) begin
            #3;
            if (vo[1] && got_at == 0) begin
                got_at = i; got_err = erro[1]; got_data = datao[1];
            end
            cyc();
            if (got_at != 0) break;
        end
        chk("t6_timeout_cycle", 64'(got_at),   64'd8);
        chk("t6_timeout_err",   64'(got_err),  64'd1);
        chk("t6_timeout_data",  64'(got_data), 64'hFFFFFFFF);
        beat(1, 16'h1111);
        beat(1, 16'h2222);
        #3;
        chk("t6_late_dropped", 64'(vo[1]), 64'd0);
        cyc();
        send(1, 1'b0, 32'hA0, 32'h0, 4'h0, 8'h07, 8'h08);
        beat(1, 16'h3333);
        beat(1, 16'h4444);
        #3;
        chk("t6_next_v",    64'(vo[1]),    64'd1);
        chk("t6_next_data", 64'(datao[1]), 64'h44443333);
        chk("t6_next_err",  64'(erro[1]),  64'd0);
        cyc();
        repeat (8) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
